// File: rtl/key_sender_if.sv
// Key sender bus: request/key/verdict in, cable symbols, strobe and status out.
interface key_sender_if;
  logic       start;
  logic [7:0] keyIn;
  logic [1:0] keyStatus;
  logic       cable1;
  logic       cable2;
  logic       pulsed;
  logic       busy;
  logic       done;
  logic [1:0] result;

  modport master (
    output start, keyIn, keyStatus,
    input  cable1, cable2, pulsed, busy, done, result
  );

  modport slave (
    input  start, keyIn, keyStatus,
    output cable1, cable2, pulsed, busy, done, result
  );
endinterface

// File: rtl/key_sender.sv
// key_sender: sends an 8-bit key as four strobed 2-bit symbols, then captures the verdict.
// Optional KEY_SENDER_RETRY_EN: one automatic resend after an ERROR verdict.
module key_sender #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2,
  parameter int RESP_WAIT = 4
) (
  input logic         clk,
  input logic         reset,
  key_sender_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_GAP, S_RESP, S_DONE
  } state_t;

  localparam logic [1:0] ST_ERROR  = 2'd2;
  localparam logic [1:0] ST_NOKEY  = 2'd3;
  localparam logic [3:0] SETUP_END = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_END = 4'(PULSE_CYC - 1);
  localparam logic [3:0] GAP_END   = 4'(GAP_CYC - 1);
  localparam logic [3:0] RESP_CAP  = 4'(RESP_WAIT - 1);
  localparam logic [3:0] RESP_LAST = 4'(RESP_WAIT);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_idx;
  logic [7:0] r_key;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic       r_cable1;
  logic       r_cable2;
  logic       r_pulsed;
  logic       r_busy;
  logic       r_done;
  logic [1:0] r_result;
`ifdef KEY_SENDER_RETRY_EN
  logic       r_retried;
`endif

  logic [1:0] w_next_sym;
  assign w_next_sym = r_key[{r_idx + 2'd1, 1'b0} +: 2];

  // keyStatus is asynchronous to clk
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= ST_NOKEY;
      r_sync2 <= ST_NOKEY;
    end else begin
      r_sync1 <= bus.keyStatus;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_key    <= '0;
      r_cable1 <= 1'b0;
      r_cable2 <= 1'b0;
      r_pulsed <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= ST_NOKEY;
`ifdef KEY_SENDER_RETRY_EN
      r_retried <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_key    <= bus.keyIn;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_cable1 <= bus.keyIn[1];
            r_cable2 <= bus.keyIn[0];
            r_busy   <= 1'b1;
            r_state  <= S_SETUP;
`ifdef KEY_SENDER_RETRY_EN
            r_retried <= 1'b0;
`endif
          end
        end
        S_SETUP: begin
          if (r_cnt == SETUP_END) begin
            r_cnt    <= '0;
            r_pulsed <= 1'b1;
            r_state  <= S_PULSE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_PULSE: begin
          if (r_cnt == PULSE_END) begin
            r_cnt    <= '0;
            r_pulsed <= 1'b0;
            r_state  <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_END) begin
            r_cnt <= '0;
            if (r_idx == 2'd3) begin
              r_state <= S_RESP;
            end else begin
              r_idx    <= r_idx + 2'd1;
              r_cable1 <= w_next_sym[1];
              r_cable2 <= w_next_sym[0];
              r_state  <= S_SETUP;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESP: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == RESP_CAP) begin
            r_result <= r_sync2;
`ifdef KEY_SENDER_RETRY_EN
            if (!r_retried && r_sync2 == ST_ERROR) begin
              r_retried <= 1'b1;
              r_idx     <= '0;
              r_cnt     <= '0;
              r_cable1  <= r_key[1];
              r_cable2  <= r_key[0];
              r_state   <= S_SETUP;
            end
`endif
          end
          // one settle cycle after capture before done
          if (r_cnt == RESP_LAST) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cable1 = r_cable1;
  assign bus.cable2 = r_cable2;
  assign bus.pulsed = r_pulsed;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
endmodule

// File: tb/tb_key_sender.sv
// Self-checking bench for key_sender: scoreboarded symbols, latency and reset.
// Retry expectations follow KEY_SENDER_RETRY_EN.
module tb_key_sender;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_sender_if bus ();
  key_sender_if bus_f ();

  key_sender u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  key_sender #(
    .SETUP_CYC (1),
    .PULSE_CYC (1),
    .GAP_CYC   (1),
    .RESP_WAIT (3)
  ) u_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_f)
  );

`ifdef KEY_SENDER_RETRY_EN
  localparam int ERR_LAT = 57;
  localparam int ERR_SYMS = 8;
`else
  localparam int ERR_LAT = 29;
  localparam int ERR_SYMS = 4;
`endif

  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  logic       prev_p = 1'b0;
  logic [1:0] prev_c = 2'b00;
  int         hi_len = 0;
  int         stab_bad = 0;
  int         width_bad = 0;
  int         done_cnt = 0;
  int         e0 = 0;

  // monitor: records strobed symbols and strobe/cable behaviour
  always @(negedge clk) begin
    if (bus.pulsed && !prev_p)
      obs_q.push_back({bus.cable1, bus.cable2});
    if (bus.pulsed && {bus.cable1, bus.cable2} != prev_c)
      stab_bad <= stab_bad + 1;
    if (!bus.pulsed && prev_p && hi_len != 2)
      width_bad <= width_bad + 1;
    hi_len <= bus.pulsed ? hi_len + 1 : 0;
    if (bus.done) done_cnt <= done_cnt + 1;
    prev_p <= bus.pulsed;
    prev_c <= {bus.cable1, bus.cable2};
  end

  task automatic push_key(input logic [7:0] key);
    for (int i = 0; i < 4; i++) exp_q.push_back(key[2*i +: 2]);
  endtask

  task automatic kick(input logic [7:0] key);
    @(negedge clk);
    bus.start = 1'b1;
    bus.keyIn = key;
    push_key(key);
    @(posedge clk);
    @(negedge clk);
    e0 = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.done === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) $display("FAIL done_timeout no done within 200 cycles");
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.keyIn = 8'hE4;
    bus.keyStatus = 2'd0;
    bus_f.start = 1'b0;
    bus_f.keyIn = 8'h00;
    bus_f.keyStatus = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pulsed !== 1'b0 || bus.cable1 !== 1'b0 || bus.cable2 !== 1'b0) begin
      errors++;
      $display("FAIL rst_lines got p%b c%b%b want p0 c00",
               bus.pulsed, bus.cable1, bus.cable2);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_status got busy%b done%b want 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.result !== 2'd3) begin
      errors++;
      $display("FAIL rst_result got %0d want 3", bus.result);
    end
    checks++;
    if (bus_f.result !== 2'd3 || bus_f.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_fast got r%0d b%b want r3 b0", bus_f.result, bus_f.busy);
    end
    exp_q.delete();
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int at;
    int n;
    logic [1:0] e;
    logic [1:0] o;
    bus.keyStatus = 2'd0;
    kick(8'hE4);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b want 1", bus.busy);
    end
    wait_done(at);
    checks++;
    if (at - e0 !== 29) begin
      errors++;
      $display("FAIL basic_latency got %0d want 29", at - e0);
    end
    checks++;
    if (bus.result !== 2'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done got r%0d b%b want r0 b1", bus.result, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got b%b d%b want 0 0", bus.busy, bus.done);
    end
    checks++;
    if (stab_bad !== 0 || width_bad !== 0) begin
      errors++;
      $display("FAIL basic_strobe got stab%0d width%0d want 0 0", stab_bad, width_bad);
    end
    n = obs_q.size();
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL basic_pulses got %0d want 4", n);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic_sym got %b want %b", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_error();
    int at;
    int n;
    logic [1:0] e;
    logic [1:0] o;
    bus.keyStatus = 2'd0;
    kick(8'h1B);
    if (ERR_SYMS == 8) push_key(8'h1B);
    repeat (10) @(negedge clk);
    bus.keyStatus = 2'd2;
    wait_done(at);
    checks++;
    if (at - e0 !== ERR_LAT) begin
      errors++;
      $display("FAIL err_latency got %0d want %0d", at - e0, ERR_LAT);
    end
    checks++;
    if (bus.result !== 2'd2) begin
      errors++;
      $display("FAIL err_result got %0d want 2", bus.result);
    end
    repeat (2) @(negedge clk);
    n = obs_q.size();
    checks++;
    if (n !== ERR_SYMS) begin
      errors++;
      $display("FAIL err_pulses got %0d want %0d", n, ERR_SYMS);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL err_sym got %b want %b", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    bus.keyStatus = 2'd0;
  endtask

  task automatic test_start_ignored();
    int at;
    int d0;
    int n;
    logic [1:0] e;
    logic [1:0] o;
    d0 = done_cnt;
    kick(8'hE4);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.keyIn = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(at);
    checks++;
    if (at - e0 !== 29) begin
      errors++;
      $display("FAIL ign_latency got %0d want 29", at - e0);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_dones got %0d busy%b want 1 busy0", done_cnt - d0, bus.busy);
    end
    n = obs_q.size();
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL ign_pulses got %0d want 4", n);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ign_sym got %b want %b", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_keyin_change();
    int at;
    logic [1:0] e;
    logic [1:0] o;
    kick(8'hE4);
    repeat (2) @(negedge clk);
    bus.keyIn = 8'h00;
    wait_done(at);
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() !== 4) begin
      errors++;
      $display("FAIL keyin_pulses got %0d want 4", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL keyin_sym got %b want %b", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int at;
    bit hit;
    logic [1:0] e;
    logic [1:0] o;
    hit = 1'b0;
    kick(8'hE4);
    for (int i = 0; i < 40; i++) begin
      if (obs_q.size() == 2 && bus.pulsed === 1'b1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_second_pulse got none want pulse 2");
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.pulsed !== 1'b0 || {bus.cable1, bus.cable2} !== 2'b00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort got p%b c%b%b b%b want 0 00 0",
               bus.pulsed, bus.cable1, bus.cable2, bus.busy);
    end
    reset = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (obs_q.size() !== 2 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_resume got %0d pulses b%b want 2 b0", obs_q.size(), bus.busy);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mid_sym got %b want %b", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    kick(8'h9C);
    wait_done(at);
    repeat (2) @(negedge clk);
    checks++;
    if (at - e0 !== 29 || obs_q.size() !== 4) begin
      errors++;
      $display("FAIL mid_restart got lat%0d n%0d want 29 4", at - e0, obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mid_restart_sym got %b want %b", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int at;
    logic [1:0] e;
    logic [1:0] o;
    @(negedge clk);
    bus.start = 1'b1;
    bus.keyIn = 8'hE4;
    push_key(8'hE4);
    push_key(8'hE4);
    @(posedge clk);
    @(negedge clk);
    e0 = cyc;
    wait_done(at);
    checks++;
    if (at - e0 !== 29) begin
      errors++;
      $display("FAIL b2b_first got %0d want 29", at - e0);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got %b want 0", bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart got %b want 1", bus.busy);
    end
    bus.start = 1'b0;
    wait_done(at);
    checks++;
    if (at - e0 !== 60) begin
      errors++;
      $display("FAIL b2b_second got %0d want 60", at - e0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() !== 8) begin
      errors++;
      $display("FAIL b2b_pulses got %0d want 8", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_sym got %b want %b", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_unexpected();
    int at;
    bus.keyStatus = 2'd1;
    kick(8'h5A);
    wait_done(at);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.result !== 2'd1) begin
      errors++;
      $display("FAIL unexp_result got %0d want 1", bus.result);
    end
    exp_q.delete();
    obs_q.delete();
    bus.keyStatus = 2'd0;
  endtask

  task automatic test_fast();
    logic [7:0] key;
    logic [1:0] sym;
    logic [1:0] pc;
    logic [1:0] hold;
    logic pp;
    int at;
    int n;
    key = 8'h6C;
    at = -1;
    n = 0;
    pp = 1'b0;
    hold = 2'b00;
    @(negedge clk);
    bus_f.start = 1'b1;
    bus_f.keyIn = key;
    @(posedge clk);
    @(negedge clk);
    e0 = cyc;
    bus_f.start = 1'b0;
    pc = {bus_f.cable1, bus_f.cable2};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_f.pulsed && !pp) begin
        sym = key[2*n +: 2];
        checks++;
        if ({bus_f.cable1, bus_f.cable2} !== sym || pc !== sym) begin
          errors++;
          $display("FAIL fast_sym got %b prev %b want %b",
                   {bus_f.cable1, bus_f.cable2}, pc, sym);
        end
        hold = {bus_f.cable1, bus_f.cable2};
        n++;
      end else if (bus_f.pulsed) begin
        checks++;
        if ({bus_f.cable1, bus_f.cable2} !== hold) begin
          errors++;
          $display("FAIL fast_hold got %b want %b", {bus_f.cable1, bus_f.cable2}, hold);
        end
      end
      if (bus_f.done === 1'b1 && at < 0) at = cyc;
      pp = bus_f.pulsed;
      pc = {bus_f.cable1, bus_f.cable2};
    end
    checks++;
    if (at - e0 !== 16 || n !== 4) begin
      errors++;
      $display("FAIL fast_latency got lat%0d n%0d want 16 4", at - e0, n);
    end
    checks++;
    if (bus_f.result !== 2'd0 || bus_f.busy !== 1'b0) begin
      errors++;
      $display("FAIL fast_result got r%0d b%b want r0 b0", bus_f.result, bus_f.busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_start_ignored();
    test_keyin_change();
    test_back_to_back();
    test_unexpected();
    test_reset_mid();
    test_fast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
